// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the wb_ram pipelined Wishbone slave RAM.
package wb_ram_pkg;

    localparam int WB_COM_AWIDTH = 32;
    localparam int WB_COM_DWIDTH = 32;
    localparam int RESP_LATENCY  = 2;
    localparam int IDX_W_MAX     = 32;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    // Request held in the access stage; idx is sized for the largest array.
    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic                 err;
        logic [IDX_W_MAX-1:0] idx;
        logic [3:0]           sel;
        logic [31:0]          wdata;
    } stage_t;

endpackage

// File: rtl/wb_ram_array.sv
// Single-port synchronous RAM, DEPTH x 32, byte write enables, registered read data.
module wb_ram_array #(
    parameter  int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing it is the controller's job, and a reset
    // term here would prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_ram.sv
// Pipelined Wishbone B4 slave RAM with a fixed 2-cycle response and an error response for bad addresses.
// Optional zero-fill after reset is enabled by defining WB_RAM_ZERO_INIT_EN.
module wb_ram
    import wb_ram_pkg::*;
#(
    parameter int                AWIDTH    = WB_COM_AWIDTH,
    parameter int                DWIDTH    = WB_COM_DWIDTH,
    parameter int                DEPTH     = 1024,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0001_0000)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [AWIDTH-1:0]   wb_adr_i,
    input  logic [DWIDTH-1:0]   wb_dat_i,
    input  logic [DWIDTH/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic [DWIDTH-1:0]   wb_dat_o,
    output logic                wb_stall_o,
    output logic                wb_ack_o,
    output logic                wb_err_o
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [AWIDTH-1:0] SPAN  = AWIDTH'(4 * DEPTH);

    state_e            state;
    stage_t            s1;
    logic              ack_q;
    logic              err_q;
    logic              rd_q;
    logic              accept;
    logic              req_err;
    logic              s1_live;
    logic [AWIDTH-1:0] offset;
    logic [3:0]        ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              unused;

`ifdef WB_RAM_ZERO_INIT_EN
    localparam state_e RESET_STATE = INIT;
    logic [IDX_W-1:0]  init_cnt;
`else
    localparam state_e RESET_STATE = READY;
`endif

    assign accept  = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign offset  = wb_adr_i - BASE_ADDR;
    assign req_err = (|wb_adr_i[1:0]) | (wb_adr_i < BASE_ADDR) | (offset >= SPAN);
    // Dropping cyc aborts whatever sits in S1: no write, no response.
    assign s1_live = s1.valid & wb_cyc_i;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        s1.we    <= wb_we_i;
        s1.err   <= req_err;
        s1.idx   <= IDX_W_MAX'(offset[IDX_W+1:2]);
        s1.sel   <= wb_sel_i;
        s1.wdata <= wb_dat_i;
        if (wb_rst_i) begin
            s1.valid <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            s1.valid <= accept;
            ack_q    <= s1_live & ~s1.err;
            err_q    <= s1_live & s1.err;
            rd_q     <= s1_live & ~s1.err & ~s1.we;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= RESET_STATE;
            wb_stall_o <= 1'b1;
`ifdef WB_RAM_ZERO_INIT_EN
            init_cnt   <= '0;
`endif
        end else begin
            case (state)
                INIT: begin
                    wb_stall_o <= 1'b1;
`ifdef WB_RAM_ZERO_INIT_EN
                    init_cnt   <= init_cnt + 1'b1;
                    if (init_cnt == IDX_W'(DEPTH - 1)) begin
                        state <= READY;
                    end
`else
                    state      <= READY;
`endif
                end
                default: wb_stall_o <= 1'b0;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ram_we    = (s1_live & s1.we & ~s1.err) ? s1.sel : 4'h0;
        ram_addr  = s1.idx[IDX_W-1:0];
        ram_wdata = s1.wdata;
`ifdef WB_RAM_ZERO_INIT_EN
        if (state == INIT) begin
            ram_we    = 4'hF;
            ram_addr  = init_cnt;
            ram_wdata = '0;
        end
`endif
    end

    wb_ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (wb_clk_i),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = rd_q ? ram_rdata : '0;

    assign unused = ^{s1.idx[IDX_W_MAX-1:IDX_W], offset[1:0]};

endmodule
